lab5_control: RTL
=================

Name: lab5_control

Overview:
- FSM controller that sequences the linked-list accumulator datapath (Lab5Datapath) through a full list traversal.
- The list head is block-RAM address 0. Each node is {data at ptr, next pointer at ptr+1}. A next pointer of 0 terminates the list.
- Drives addr_sel, wr_en and alu_op, consumes ram_zero, and exposes a start/busy/done handshake plus a node count and a runaway-list error flag to the top level.

Parameters:
- READ_LAT, 1, block-RAM read latency in cycles (address applied to douta/ram_zero valid); legal 1..3.
- MAX_NODES, 255, maximum nodes accumulated before the traversal is aborted with error; legal 1..255.
- OP_NOP, 4'h0, alu_op code: datapath registers hold.
- OP_CLR, 4'h1, alu_op code: accum<=0, ptr<=0.
- OP_ADD, 4'h2, alu_op code: accum<=accum+douta.
- OP_LDPTR, 4'h3, alu_op code: ptr<=douta.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin traversal; sampled only in IDLE.
- ram_zero  input  1  datapath flag, douta==0; valid READ_LAT cycles after the address is stable.
- addr_sel  output  1  0: RAM address=ptr (data word); 1: RAM address=ptr+1 (next word).
- wr_en  output  1  datapath register write enable for the operation on alu_op.
- alu_op  output  4  datapath operation code (OP_* parameters).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the traversal ends (normal or error).
- error  output  1  set when traversal aborted at MAX_NODES; held until next accepted start or reset.
- node_count  output  8  number of OP_ADD operations issued in the current or last traversal.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, lat counter=0, node_count=0, error=0. Outputs: addr_sel=0, wr_en=0, alu_op=OP_NOP, busy=0, done=0. Reset mid-traversal aborts immediately with no done pulse.
- Outputs are Moore-decoded from state. wr_en=1 only in CLR, ADD and LINK-with-load.
- IDLE: outputs NOP. If start=1, go to CLR. start while busy is ignored, with no queuing.
- CLR (1 cycle): alu_op=OP_CLR, wr_en=1. Clear node_count and error. Go to FETCH_D.
- FETCH_D (READ_LAT cycles): addr_sel=0, wr_en=0, NOP. The lat counter counts to READ_LAT, then go to ADD.
- ADD (1 cycle): addr_sel=0, alu_op=OP_ADD, wr_en=1. node_count+=1. Go to FETCH_N.
- FETCH_N (READ_LAT cycles): addr_sel=1, NOP. Then go to LINK.
- LINK (1 cycle): addr_sel=1. Evaluated in priority order:
  - ram_zero=1: wr_en=0, go to DONE.
  - else if node_count==MAX_NODES: wr_en=0, set error, go to DONE.
  - else: alu_op=OP_LDPTR, wr_en=1, go to FETCH_D.
- DONE (1 cycle): done=1, busy=0, NOP. Go to IDLE. A start in DONE is ignored.
- Latency: start sampled at edge k gives CLR in cycle k+1. Each node takes 2*(READ_LAT+1) cycles. done is high in cycle k+2+2N*(READ_LAT+1) for an N-node list.
- busy=1 in CLR, FETCH_D, ADD, FETCH_N and LINK only.
- node_count saturates by construction at MAX_NODES. It never wraps and holds its value after done until the next CLR.
- Data value 0 in a node is legal and is still counted. Only a zero next-pointer terminates the list.
- Self-loop or cyclic list: terminates through the MAX_NODES path with error=1.

Test Plan:
- RAM {0:5, 1:0}, READ_LAT=1, start pulse at edge k → alu_op sequence CLR, NOP, ADD, NOP, NOP (LINK, ram_zero=1); accum_result=5; node_count=1; done pulse in cycle k+6; error=0.
- RAM {0:3, 1:4, 4:10, 5:8, 8:7, 9:0} → three LDPTR-free/LDPTR hops (2 LDPTR issued); accum_result=20; node_count=3; done in cycle k+14.
- RAM {0:1, 1:0x2, 2:1, 3:0x0? no → 3:0x2} (cycle 2→2), MAX_NODES=4 → node_count=4, error=1, done pulse, accum_result=4; next start clears error.
- start held high throughout a 3-node traversal → exactly one traversal and one done pulse; IDLE re-accepts start the cycle after DONE.
- rst=0 asserted asynchronously mid-FETCH_N → outputs immediately NOP/0, busy=0, no done pulse; a fresh start gives a correct result from CLR.
- READ_LAT=2, single-node list {0:9, 1:0} → wr_en high only in CLR and ADD; ADD occurs 3 cycles after CLR; done in cycle k+8; accum_result=9.

Source files
------------

// File: rtl/lab5_control_if.sv
// Bus between the list-traversal controller, its datapath and the host:
// datapath control (addr_sel/wr_en/alu_op/ram_zero) plus the start/busy/done status handshake.
interface lab5_control_if;
    logic       start;
    logic       ram_zero;
    logic       addr_sel;
    logic       wr_en;
    logic [3:0] alu_op;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] node_count;

    modport master (
        input  start, ram_zero,
        output addr_sel, wr_en, alu_op, busy, done, error, node_count
    );

    modport slave (
        output start, ram_zero,
        input  addr_sel, wr_en, alu_op, busy, done, error, node_count
    );
endinterface

// File: rtl/lab5_control.sv
// Linked-list accumulator controller: walks the list from address 0, issuing CLR/ADD/LDPTR
// to the datapath, and stops on a zero next pointer or after MAX_NODES nodes (error).
module lab5_control #(
    parameter int         READ_LAT  = 1,
    parameter int         MAX_NODES = 255,
    parameter logic [3:0] OP_NOP    = 4'h0,
    parameter logic [3:0] OP_CLR    = 4'h1,
    parameter logic [3:0] OP_ADD    = 4'h2,
    parameter logic [3:0] OP_LDPTR  = 4'h3
) (
    input  logic           clk,
    input  logic           rst,
    lab5_control_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_FETCH_D, S_ADD, S_FETCH_N, S_LINK, S_DONE
    } state_t;

    localparam logic [1:0] LAT_LAST  = 2'(READ_LAT - 1);
    localparam logic [7:0] NODE_LIMIT = 8'(MAX_NODES);

    state_t     state_reg, state_next;
    logic [1:0] lat_reg, lat_next;
    logic [7:0] node_count_reg, node_count_next;
    logic       error_reg, error_next;

    logic       addr_sel, wr_en, busy, done;
    logic [3:0] alu_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            lat_reg        <= 2'd0;
            node_count_reg <= 8'd0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lat_reg        <= lat_next;
            node_count_reg <= node_count_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lat_next        = lat_reg;
        node_count_next = node_count_reg;
        error_next      = error_reg;
        addr_sel        = 1'b0;
        wr_en           = 1'b0;
        alu_op          = OP_NOP;
        busy            = 1'b0;
        done            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) state_next = S_CLR;
            end
            S_CLR: begin
                busy            = 1'b1;
                alu_op          = OP_CLR;
                wr_en           = 1'b1;
                node_count_next = 8'd0;
                error_next      = 1'b0;
                lat_next        = 2'd0;
                state_next      = S_FETCH_D;
            end
            S_FETCH_D: begin
                busy = 1'b1;
                if (lat_reg == LAT_LAST) begin
                    lat_next   = 2'd0;
                    state_next = S_ADD;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            S_ADD: begin
                busy            = 1'b1;
                alu_op          = OP_ADD;
                wr_en           = 1'b1;
                node_count_next = node_count_reg + 8'd1;
                state_next      = S_FETCH_N;
            end
            S_FETCH_N: begin
                busy     = 1'b1;
                addr_sel = 1'b1;
                if (lat_reg == LAT_LAST) begin
                    lat_next   = 2'd0;
                    state_next = S_LINK;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            S_LINK: begin
                busy     = 1'b1;
                addr_sel = 1'b1;
                // A zero next pointer wins over the node limit: a list of exactly
                // MAX_NODES nodes still finishes cleanly.
                if (bus.ram_zero) begin
                    state_next = S_DONE;
                end else if (node_count_reg == NODE_LIMIT) begin
                    error_next = 1'b1;
                    state_next = S_DONE;
                end else begin
                    alu_op     = OP_LDPTR;
                    wr_en      = 1'b1;
                    state_next = S_FETCH_D;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.addr_sel   = addr_sel;
    assign bus.wr_en      = wr_en;
    assign bus.alu_op     = alu_op;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error_reg;
    assign bus.node_count = node_count_reg;

endmodule
